dag_unit: RTL and testbench

Data address generator for the processor. Holds eight index (I), modify (M), length (L) and base (B) registers, all 16 bits. Each enabled cycle it produces either a data-memory address or a program-sequencer jump target, applying pre-modify or post-modify addressing with optional circular-buffer wrap. It sits beside the program sequencer: it consumes the sequencer's `ps_dg_*` decode strobes and `bc_dt` write data, and returns `dg_ps_add` for jumps, `dg_dm_add` for data memory, and `dg_bc_dt` for ureg reads.

---
 rtl/dag_unit.sv | 105 ++++++++++
 tb/tb_dag_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dag_unit.sv
// Data address generator: eight I/M/L/B register sets, post/pre-modify addressing
// with circular-buffer wrap, ureg read/write port with same-cycle bypass.
module dag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_dg_en,
    input  logic        ps_dg_dgsclt,
    input  logic        ps_dg_mdfy,
    input  logic [2:0]  ps_dg_iadd,
    input  logic [2:0]  ps_dg_madd,
    input  logic        ps_dg_wrt_en,
    input  logic [4:0]  ps_dg_wrt_add,
    input  logic [4:0]  ps_dg_rd_add,
    input  logic [15:0] bc_dt,
    output logic [15:0] dg_ps_add,
    output logic [15:0] dg_dm_add,
    output logic [15:0] dg_bc_dt
);

    logic [15:0] r_i [8];
    logic [15:0] r_m [8];
    logic [15:0] r_l [8];
    logic [15:0] r_b [8];

    logic [15:0] w_i;
    logic [15:0] w_m;
    logic [15:0] w_sum;
    logic [15:0] w_next;
    logic [15:0] w_addr;
    logic [15:0] w_rd;
    logic        w_byp;

    // Circular-buffer step; the 17-bit compare keeps B+L from overflowing near 0xFFFF.
    function automatic logic [15:0] f_circ_next(input logic [15:0] a_i,
                                                input logic [15:0] a_m,
                                                input logic [15:0] a_l,
                                                input logic [15:0] a_b);
        logic [15:0] s;
        logic [16:0] top;
        s   = a_i + a_m;
        top = {1'b0, a_b} + {1'b0, a_l};
        if (a_l == 16'd0)
            return s;
        else if ({1'b0, s} >= top)
            return s - a_l;
        else if (s < a_b)
            return s + a_l;
        else
            return s;
    endfunction

    assign w_i    = r_i[ps_dg_iadd];
    assign w_m    = r_m[ps_dg_madd];
    assign w_sum  = w_i + w_m;
    assign w_next = f_circ_next(w_i, w_m, r_l[ps_dg_iadd], r_b[ps_dg_iadd]);
    assign w_addr = ps_dg_mdfy ? w_sum : w_i;

    assign dg_dm_add = (ps_dg_en && !ps_dg_dgsclt) ? w_addr : 16'd0;
    assign dg_ps_add = (ps_dg_en &&  ps_dg_dgsclt) ? w_addr : 16'd0;

    always_comb begin
        w_rd = 16'd0;
        case (ps_dg_rd_add[4:3])
            2'b00:   w_rd = r_i[ps_dg_rd_add[2:0]];
            2'b01:   w_rd = r_m[ps_dg_rd_add[2:0]];
            2'b10:   w_rd = r_l[ps_dg_rd_add[2:0]];
            default: w_rd = r_b[ps_dg_rd_add[2:0]];
        endcase
    end

    // A B[n] write also loads I[n], so it must bypass to an I[n] read as well.
    assign w_byp = ps_dg_wrt_en &&
                   ((ps_dg_wrt_add == ps_dg_rd_add) ||
                    (ps_dg_wrt_add[4:3] == 2'b11 && ps_dg_rd_add[4:3] == 2'b00 &&
                     ps_dg_wrt_add[2:0] == ps_dg_rd_add[2:0]));

    assign dg_bc_dt = w_byp ? bc_dt : w_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_i[k] <= 16'd0;
                r_m[k] <= 16'd0;
                r_l[k] <= 16'd0;
                r_b[k] <= 16'd0;
            end
        end else begin
            if (ps_dg_en && !ps_dg_mdfy)
                r_i[ps_dg_iadd] <= w_next;
            // Ureg write is issued last so it overrides a colliding post-modify.
            if (ps_dg_wrt_en) begin
                case (ps_dg_wrt_add[4:3])
                    2'b00: r_i[ps_dg_wrt_add[2:0]] <= bc_dt;
                    2'b01: r_m[ps_dg_wrt_add[2:0]] <= bc_dt;
                    2'b10: r_l[ps_dg_wrt_add[2:0]] <= bc_dt;
                    default: begin
                        r_b[ps_dg_wrt_add[2:0]] <= bc_dt;
                        r_i[ps_dg_wrt_add[2:0]] <= bc_dt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dag_unit.sv
// Directed bench for dag_unit: addressing modes, circular wrap, ureg bypass and resets.
module tb_dag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_dg_en;
    logic        ps_dg_dgsclt;
    logic        ps_dg_mdfy;
    logic [2:0]  ps_dg_iadd;
    logic [2:0]  ps_dg_madd;
    logic        ps_dg_wrt_en;
    logic [4:0]  ps_dg_wrt_add;
    logic [4:0]  ps_dg_rd_add;
    logic [15:0] bc_dt;
    logic [15:0] dg_ps_add;
    logic [15:0] dg_dm_add;
    logic [15:0] dg_bc_dt;

    int checks = 0;
    int failures = 0;

    dag_unit dut (
        .clk(clk), .rst(rst),
        .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
        .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
        .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
        .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt),
        .dg_ps_add(dg_ps_add), .dg_dm_add(dg_dm_add), .dg_bc_dt(dg_bc_dt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: applied at the falling edge, outputs settle 1ns later.
    task automatic drive(input logic r, input logic en, input logic sclt, input logic mdfy,
                         input logic [2:0] ia, input logic [2:0] ma, input logic wen,
                         input logic [4:0] wa, input logic [15:0] d, input logic [4:0] ra);
        @(negedge clk);
        rst = r; ps_dg_en = en; ps_dg_dgsclt = sclt; ps_dg_mdfy = mdfy;
        ps_dg_iadd = ia; ps_dg_madd = ma; ps_dg_wrt_en = wen;
        ps_dg_wrt_add = wa; bc_dt = d; ps_dg_rd_add = ra;
        #1;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [15:0] d);
        drive(0, 0, 0, 0, 3'd0, 3'd0, 1, wa, d, 5'd0);
    endtask

    task automatic rd(input logic [4:0] ra);
        drive(0, 0, 0, 0, 3'd0, 3'd0, 0, 5'd0, 16'd0, ra);
    endtask

    task automatic post_mod(input logic [2:0] ia, input logic [2:0] ma);
        drive(0, 1, 0, 0, ia, ma, 0, 5'd0, 16'd0, 5'd0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 5'd0, 16'd0, 5'd0);
        drive(1, 0, 0, 0, 3'd0, 3'd0, 0, 5'd0, 16'd0, 5'd0);
        rd(5'b00000);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL reset_I0 got=%h exp=0000", dg_bc_dt); end
        checks++; if (dg_dm_add !== 16'h0000) begin failures++; $display("FAIL reset_dm got=%h exp=0000", dg_dm_add); end
        checks++; if (dg_ps_add !== 16'h0000) begin failures++; $display("FAIL reset_ps got=%h exp=0000", dg_ps_add); end
        rd(5'b11111);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL reset_B7 got=%h exp=0000", dg_bc_dt); end
    endtask

    task automatic test_linear();
        wr(5'b00000, 16'h0010);
        wr(5'b01000, 16'h0002);
        post_mod(3'd0, 3'd0);
        checks++; if (dg_dm_add !== 16'h0010) begin failures++; $display("FAIL lin_a0 got=%h exp=0010", dg_dm_add); end
        checks++; if (dg_ps_add !== 16'h0000) begin failures++; $display("FAIL lin_ps0 got=%h exp=0000", dg_ps_add); end
        post_mod(3'd0, 3'd0);
        checks++; if (dg_dm_add !== 16'h0012) begin failures++; $display("FAIL lin_a1 got=%h exp=0012", dg_dm_add); end
        post_mod(3'd0, 3'd0);
        checks++; if (dg_dm_add !== 16'h0014) begin failures++; $display("FAIL lin_a2 got=%h exp=0014", dg_dm_add); end
        rd(5'b00000);
        checks++; if (dg_bc_dt !== 16'h0016) begin failures++; $display("FAIL lin_I0 got=%h exp=0016", dg_bc_dt); end
    endtask

    task automatic test_circular();
        logic [15:0] exp_a [4];
        exp_a[0] = 16'h0100; exp_a[1] = 16'h0103; exp_a[2] = 16'h0102; exp_a[3] = 16'h0101;
        wr(5'b11001, 16'h0100);
        wr(5'b10001, 16'h0004);
        wr(5'b01001, 16'h0003);
        rd(5'b00001);
        checks++; if (dg_bc_dt !== 16'h0100) begin failures++; $display("FAIL circ_Iload got=%h exp=0100", dg_bc_dt); end
        for (int k = 0; k < 4; k++) begin
            post_mod(3'd1, 3'd1);
            checks++; if (dg_dm_add !== exp_a[k]) begin failures++; $display("FAIL circ_a%0d got=%h exp=%h", k, dg_dm_add, exp_a[k]); end
        end
        rd(5'b00001);
        checks++; if (dg_bc_dt !== 16'h0100) begin failures++; $display("FAIL circ_Iend got=%h exp=0100", dg_bc_dt); end
        wr(5'b01001, 16'hFFFF);
        post_mod(3'd1, 3'd1);
        checks++; if (dg_dm_add !== 16'h0100) begin failures++; $display("FAIL circ_neg_a got=%h exp=0100", dg_dm_add); end
        rd(5'b00001);
        checks++; if (dg_bc_dt !== 16'h0103) begin failures++; $display("FAIL circ_neg_I got=%h exp=0103", dg_bc_dt); end
    endtask

    task automatic test_premodify();
        wr(5'b00010, 16'h0040);
        wr(5'b01011, 16'hFFF0);
        drive(0, 1, 1, 1, 3'd2, 3'd3, 0, 5'd0, 16'd0, 5'd0);
        checks++; if (dg_ps_add !== 16'h0030) begin failures++; $display("FAIL pre_ps got=%h exp=0030", dg_ps_add); end
        checks++; if (dg_dm_add !== 16'h0000) begin failures++; $display("FAIL pre_dm got=%h exp=0000", dg_dm_add); end
        rd(5'b00010);
        checks++; if (dg_bc_dt !== 16'h0040) begin failures++; $display("FAIL pre_I2 got=%h exp=0040", dg_bc_dt); end
    endtask

    task automatic test_collision();
        wr(5'b00100, 16'h0500);
        wr(5'b01100, 16'h0001);
        drive(0, 1, 0, 0, 3'd4, 3'd4, 1, 5'b00100, 16'h1234, 5'b00100);
        checks++; if (dg_bc_dt !== 16'h1234) begin failures++; $display("FAIL col_byp got=%h exp=1234", dg_bc_dt); end
        checks++; if (dg_dm_add !== 16'h0500) begin failures++; $display("FAIL col_addr got=%h exp=0500", dg_dm_add); end
        rd(5'b00100);
        checks++; if (dg_bc_dt !== 16'h1234) begin failures++; $display("FAIL col_I4 got=%h exp=1234", dg_bc_dt); end
        drive(0, 0, 0, 0, 3'd0, 3'd0, 1, 5'b11100, 16'h2222, 5'b00100);
        checks++; if (dg_bc_dt !== 16'h2222) begin failures++; $display("FAIL col_Bbyp got=%h exp=2222", dg_bc_dt); end
        rd(5'b00100);
        checks++; if (dg_bc_dt !== 16'h2222) begin failures++; $display("FAIL col_BI4 got=%h exp=2222", dg_bc_dt); end
        rd(5'b11100);
        checks++; if (dg_bc_dt !== 16'h2222) begin failures++; $display("FAIL col_B4 got=%h exp=2222", dg_bc_dt); end
        drive(0, 0, 0, 0, 3'd0, 3'd0, 1, 5'b01100, 16'h7777, 5'b00100);
        checks++; if (dg_bc_dt !== 16'h2222) begin failures++; $display("FAIL col_nobyp got=%h exp=2222", dg_bc_dt); end
    endtask

    task automatic test_wrap16();
        wr(5'b00101, 16'hFFFE);
        wr(5'b01101, 16'h0004);
        post_mod(3'd5, 3'd5);
        checks++; if (dg_dm_add !== 16'hFFFE) begin failures++; $display("FAIL w16_a got=%h exp=fffe", dg_dm_add); end
        drive(0, 0, 1, 0, 3'd5, 3'd5, 0, 5'd0, 16'd0, 5'b00101);
        checks++; if (dg_bc_dt !== 16'h0002) begin failures++; $display("FAIL w16_I5 got=%h exp=0002", dg_bc_dt); end
        checks++; if (dg_ps_add !== 16'h0000) begin failures++; $display("FAIL w16_en0_ps got=%h exp=0000", dg_ps_add); end
        checks++; if (dg_dm_add !== 16'h0000) begin failures++; $display("FAIL w16_en0_dm got=%h exp=0000", dg_dm_add); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 0, 3'd5, 3'd5, 1, 5'b00000, 16'hAAAA, 5'd0);
        rd(5'b00000);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL rmid_I0 got=%h exp=0000", dg_bc_dt); end
        rd(5'b00101);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL rmid_I5 got=%h exp=0000", dg_bc_dt); end
        rd(5'b01101);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL rmid_M5 got=%h exp=0000", dg_bc_dt); end
        rd(5'b10001);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL rmid_L1 got=%h exp=0000", dg_bc_dt); end
        rd(5'b11100);
        checks++; if (dg_bc_dt !== 16'h0000) begin failures++; $display("FAIL rmid_B4 got=%h exp=0000", dg_bc_dt); end
    endtask

    initial begin
        rst = 1'b1; ps_dg_en = 1'b0; ps_dg_dgsclt = 1'b0; ps_dg_mdfy = 1'b0;
        ps_dg_iadd = 3'd0; ps_dg_madd = 3'd0; ps_dg_wrt_en = 1'b0;
        ps_dg_wrt_add = 5'd0; ps_dg_rd_add = 5'd0; bc_dt = 16'd0;
        test_reset();
        test_linear();
        test_circular();
        test_premodify();
        test_collision();
        test_wrap16();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
